// File: rtl/bullet_pkg.sv
// Shared game types: playfield geometry, top-state codes, bullet slot record
// and the wall-bitmap addressing helper.
package bullet_pkg;

  localparam int MAP_W    = 64;
  localparam int MAP_H    = 44;
  localparam int MAP_BITS = MAP_W * MAP_H;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_PLAY   = 2'b01;
  localparam logic [1:0] ST_NEWMAP = 2'b10;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef struct packed {
    logic       valid;
    logic [5:0] x;
    logic [5:0] y;
    dir_t       dir;
    logic [5:0] life;
  } bullet_t;

  // y*64 + (63-x) is simply y concatenated with the inverted column
  function automatic logic [11:0] map_bit_idx(input logic [5:0] x, input logic [5:0] y);
    return {y, ~x};
  endfunction

endpackage

// File: rtl/bullet_step.sv
// Combinational single-step of one bullet: move, bound check, wall test, life.
module bullet_step
  import bullet_pkg::*;
(
  input  bullet_t                cur,
  input  logic [MAP_BITS-1:0]    map,
  output bullet_t                nxt,
  output logic                   hit,
  output logic [5:0]             hit_x,
  output logic [5:0]             hit_y
);

  logic signed [7:0] nx;
  logic signed [7:0] ny;
  logic              oob;
  logic              wall;

  always_comb begin
    nx = signed'({2'b00, cur.x});
    ny = signed'({2'b00, cur.y});
    case (cur.dir)
      DIR_UP:    ny = ny - 8'sd1;
      DIR_RIGHT: nx = nx + 8'sd1;
      DIR_DOWN:  ny = ny + 8'sd1;
      default:   nx = nx - 8'sd1;
    endcase

    // signed compare so a wrapped coordinate can never land in bounds
    oob  = (nx < 8'sd0) || (nx > 8'sd63) || (ny < 8'sd0) || (ny > 8'sd43);
    wall = 1'b0;
    if (!oob) begin
      wall = map[map_bit_idx(nx[5:0], ny[5:0])];
    end

    nxt   = cur;
    hit   = 1'b0;
    hit_x = nx[5:0];
    hit_y = ny[5:0];
    if (cur.valid) begin
      if (oob) begin
        nxt = '0;
      end else if (wall) begin
        nxt = '0;
        hit = 1'b1;
      end else if (cur.life == 6'd1) begin
        nxt = '0;
      end else begin
        nxt.x    = nx[5:0];
        nxt.y    = ny[5:0];
        nxt.life = cur.life - 6'd1;
      end
    end
  end

endmodule

// File: rtl/bullet_engine.sv
// Bullet slot array with serial per-tick scan, lowest-free-slot allocator
// and registered hit strobe feeding the map generator.
module bullet_engine
  import bullet_pkg::*;
#(
  parameter int N_BULLET = 4,
  parameter int LIFE     = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              i_top_state,
  input  logic [MAP_BITS-1:0]     i_map,
  input  logic                    i_tick,
  input  logic                    i_fire,
  input  logic [5:0]              i_fire_x,
  input  logic [5:0]              i_fire_y,
  input  logic [1:0]              i_fire_dir,
  output logic                    o_fire_ready,
  output logic [5:0]              o_hit_x,
  output logic [5:0]              o_hit_y,
  output logic                    o_hit_valid,
  output logic [N_BULLET-1:0]     o_bullet_valid,
  output logic [12*N_BULLET-1:0]  o_bullet_xy
);

  localparam int IDX_W = (N_BULLET > 1) ? $clog2(N_BULLET) : 1;

  typedef enum logic {S_IDLE, S_SCAN} fsm_t;

  fsm_t             state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  bullet_t          slot_reg  [N_BULLET];
  bullet_t          slot_next [N_BULLET];
  logic             hit_valid_reg, hit_valid_next;
  logic [5:0]       hit_x_reg, hit_x_next;
  logic [5:0]       hit_y_reg, hit_y_next;
  logic             fire_ready_reg, fire_ready_next;

  bullet_t          step_nxt;
  logic             step_hit;
  logic [5:0]       step_hit_x;
  logic [5:0]       step_hit_y;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             any_free_next;

  bullet_step u_step (
    .cur   (slot_reg[idx_reg]),
    .map   (i_map),
    .nxt   (step_nxt),
    .hit   (step_hit),
    .hit_x (step_hit_x),
    .hit_y (step_hit_y)
  );

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = N_BULLET - 1; i >= 0; i--) begin
      if (!slot_reg[i].valid) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    hit_valid_next = 1'b0;
    hit_x_next     = hit_x_reg;
    hit_y_next     = hit_y_reg;
    for (int i = 0; i < N_BULLET; i++) begin
      slot_next[i] = slot_reg[i];
    end

    if (i_top_state != ST_PLAY) begin
      // leaving play aborts everything, including a scan in progress
      state_next = S_IDLE;
      idx_next   = '0;
      for (int i = 0; i < N_BULLET; i++) begin
        slot_next[i] = '0;
      end
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (i_tick) begin
            state_next = S_SCAN;
            idx_next   = '0;
          end
        end
        default: begin
          slot_next[idx_reg] = step_nxt;
          if (step_hit) begin
            hit_valid_next = 1'b1;
            hit_x_next     = step_hit_x;
            hit_y_next     = step_hit_y;
          end
          if (idx_reg == IDX_W'(N_BULLET - 1)) begin
            state_next = S_IDLE;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      endcase

      // ready is only ever high in IDLE, so this never collides with the scan write
      if (i_fire && fire_ready_reg && free_found) begin
        slot_next[free_idx].valid = 1'b1;
        slot_next[free_idx].x     = i_fire_x;
        slot_next[free_idx].y     = i_fire_y;
        slot_next[free_idx].dir   = dir_t'(i_fire_dir);
        slot_next[free_idx].life  = 6'(LIFE);
      end
    end

    any_free_next = 1'b0;
    for (int i = 0; i < N_BULLET; i++) begin
      if (!slot_next[i].valid) begin
        any_free_next = 1'b1;
      end
    end
    fire_ready_next = (i_top_state == ST_PLAY) && (state_next == S_IDLE) && any_free_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      idx_reg        <= '0;
      hit_valid_reg  <= 1'b0;
      hit_x_reg      <= '0;
      hit_y_reg      <= '0;
      fire_ready_reg <= 1'b0;
      for (int i = 0; i < N_BULLET; i++) begin
        slot_reg[i] <= '0;
      end
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      hit_valid_reg  <= hit_valid_next;
      hit_x_reg      <= hit_x_next;
      hit_y_reg      <= hit_y_next;
      fire_ready_reg <= fire_ready_next;
      for (int i = 0; i < N_BULLET; i++) begin
        slot_reg[i] <= slot_next[i];
      end
    end
  end

  assign o_fire_ready = fire_ready_reg;
  assign o_hit_valid  = hit_valid_reg;
  assign o_hit_x      = hit_x_reg;
  assign o_hit_y      = hit_y_reg;

  for (genvar gi = 0; gi < N_BULLET; gi++) begin : g_out
    assign o_bullet_valid[gi]        = slot_reg[gi].valid;
    assign o_bullet_xy[12*gi +: 12]  = {slot_reg[gi].y, slot_reg[gi].x};
  end

endmodule
